ama_riscv_imem_loader: RTL and testbench

Boot-time sequencer for the instruction memory's write port (port A: ena/wea/addra/dina).
- Receives a byte stream over a valid/ready handshake and packs bytes little-endian into 32-bit words.
- Writes each word to consecutive IMEM word addresses.
- Holds the core in reset until a complete image has been loaded.
- Sits beside the core; IMEM port B stays owned by the fetch stage.

---
 rtl/ama_riscv_imem_loader_pkg.sv | 21 ++
 rtl/ama_riscv_byte_packer.sv | 37 +++
 rtl/ama_riscv_imem_loader.sv | 188 ++++++++++++++++++
 tb/tb_ama_riscv_imem_loader.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ama_riscv_imem_loader_pkg.sv
// Shared loader definitions: FSM state encodings and the full-word write enable.
// Consumed by ama_riscv_imem_loader and its byte packer.
package ama_riscv_imem_loader_pkg;

    typedef enum logic [2:0] {
        LDR_IDLE = 3'd0,
        LDR_HDR  = 3'd1,
        LDR_LOAD = 3'd2,
        LDR_WR   = 3'd3,
        LDR_CHK  = 3'd4,
        LDR_DONE = 3'd5
    } ldr_state_e;

    localparam logic [3:0] LDR_WE_ALL = 4'hF;

    // States in which the loader drives rx_ready and runs the inter-byte timeout
    function automatic logic ldr_takes_bytes(input ldr_state_e s);
        return (s == LDR_HDR) || (s == LDR_LOAD) || (s == LDR_CHK);
    endfunction

endpackage

// File: rtl/ama_riscv_byte_packer.sv
// Packs a handshaked byte stream little-endian into 32-bit words.
// word_o is only meaningful in the cycle word_valid_o is high (4th byte handshake).
module ama_riscv_byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        hs_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);

    logic [1:0]  cnt_q;
    logic [23:0] lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 2'd0;
            lo_q  <= 24'd0;
        end else if (clr_i) begin
            cnt_q <= 2'd0;
        end else if (hs_i) begin
            cnt_q <= cnt_q + 2'd1;
            case (cnt_q)
                2'd0:    lo_q[7:0]   <= byte_i;
                2'd1:    lo_q[15:8]  <= byte_i;
                2'd2:    lo_q[23:16] <= byte_i;
                default: ;
            endcase
        end
    end

    // The 4th byte is taken straight from the input so the word is ready on its handshake
    assign word_o       = {byte_i, lo_q};
    assign word_valid_o = hs_i && (cnt_q == 2'd3);

endmodule

// File: rtl/ama_riscv_imem_loader.sv
// Boot loader for IMEM port A: header word N, then N words, core held in reset until done.
// Optional trailing checksum word enabled by defining IMEM_LOADER_CHECKSUM_EN.
module ama_riscv_imem_loader
    import ama_riscv_imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int TIMEOUT_W = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_ena,
    output logic [3:0]        imem_wea,
    output logic [ADDR_W-1:0] imem_addra,
    output logic [31:0]       imem_dina,
    output logic              core_rst,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam logic [32:0] CAP = 33'd1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam ldr_state_e AFTER_LAST = LDR_CHK;
`else
    localparam ldr_state_e AFTER_LAST = LDR_DONE;
`endif

    ldr_state_e          state_q, state_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0]   last_q, last_d;
    logic [TIMEOUT_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [31:0]         dina_q, dina_d;
    logic                rx_ready_q, ena_q, busy_q, done_q, core_rst_q;
    logic [3:0]          wea_q;
    logic [ADDR_W-1:0]   addra_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    logic        hs, timed, pk_clr, pk_valid;
    logic [31:0] pk_word;

    assign hs      = rx_valid && rx_ready_q;
    assign timed   = ldr_takes_bytes(state_q);
    assign tmo_inc = tmo_q + 1'b1;

    ama_riscv_byte_packer u_packer (
        .clk          (clk),
        .rst          (rst),
        .clr_i        (pk_clr),
        .hs_i         (hs),
        .byte_i       (rx_data),
        .word_o       (pk_word),
        .word_valid_o (pk_valid)
    );

    always_comb begin
        state_d    = state_q;
        err_d      = err_q;
        word_cnt_d = word_cnt_q;
        last_d     = last_q;
        tmo_d      = tmo_q;
        dina_d     = dina_q;
        pk_clr     = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        if (timed) tmo_d = hs ? '0 : tmo_inc;
        case (state_q)
            LDR_IDLE, LDR_DONE: begin
                if (start) begin
                    state_d    = LDR_HDR;
                    err_d      = 1'b0;
                    word_cnt_d = '0;
                    tmo_d      = '0;
                    pk_clr     = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = 32'd0;
`endif
                end
            end
            LDR_HDR: begin
                if (pk_valid) begin
                    if (pk_word == 32'd0) begin
                        state_d = AFTER_LAST;
                    end else if ({1'b0, pk_word} > CAP) begin
                        err_d   = 1'b1;
                        state_d = LDR_IDLE;
                    end else begin
                        last_d  = ADDR_W'(pk_word - 32'd1);
                        state_d = LDR_LOAD;
                    end
                end
            end
            LDR_LOAD: begin
                if (pk_valid) begin
                    dina_d  = pk_word;
                    state_d = LDR_WR;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = sum_q + pk_word;
`endif
                end
            end
            LDR_WR: begin
                if (word_cnt_q == last_q) begin
                    state_d = AFTER_LAST;
                end else begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    state_d    = LDR_LOAD;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            LDR_CHK: begin
                if (pk_valid) begin
                    if (pk_word == sum_q) begin
                        state_d = LDR_DONE;
                    end else begin
                        err_d   = 1'b1;
                        state_d = LDR_IDLE;
                    end
                end
            end
`endif
            default: state_d = LDR_IDLE;
        endcase
        // Counter is about to reach all-ones on an idle cycle: abandon the load
        if (timed && !hs && (&tmo_inc)) begin
            err_d   = 1'b1;
            state_d = LDR_IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= LDR_IDLE;
            err_q      <= 1'b0;
            word_cnt_q <= '0;
            last_q     <= '0;
            tmo_q      <= '0;
            dina_q     <= 32'd0;
            rx_ready_q <= 1'b0;
            ena_q      <= 1'b0;
            wea_q      <= 4'd0;
            addra_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            core_rst_q <= 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            err_q      <= err_d;
            word_cnt_q <= word_cnt_d;
            last_q     <= last_d;
            tmo_q      <= tmo_d;
            dina_q     <= dina_d;
            // Outputs are registered from the next state so they line up with it
            rx_ready_q <= ldr_takes_bytes(state_d);
            ena_q      <= (state_d == LDR_WR);
            wea_q      <= (state_d == LDR_WR) ? LDR_WE_ALL : 4'd0;
            if (state_d == LDR_WR) addra_q <= word_cnt_q;
            busy_q     <= (state_d == LDR_HDR) || (state_d == LDR_LOAD) ||
                          (state_d == LDR_WR)  || (state_d == LDR_CHK);
            done_q     <= (state_d == LDR_DONE);
            core_rst_q <= (state_d != LDR_DONE);
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_ena   = ena_q;
    assign imem_wea   = wea_q;
    assign imem_addra = addra_q;
    assign imem_dina  = dina_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign core_rst   = core_rst_q;

endmodule

// File: tb/tb_ama_riscv_imem_loader.sv
// Self-checking bench for ama_riscv_imem_loader (TIMEOUT_W=4, so timeout after 15 idle cycles).
// Follows IMEM_LOADER_CHECKSUM_EN if defined, sending the trailing sum word.
module tb_ama_riscv_imem_loader;

    localparam int ADDR_W = 14;

    logic              clk = 1'b0;
    logic              rst, start, rx_valid, rx_ready;
    logic [7:0]        rx_data;
    logic              imem_ena, core_rst, busy, done, err;
    logic [3:0]        imem_wea;
    logic [ADDR_W-1:0] imem_addra;
    logic [31:0]       imem_dina;

    ama_riscv_imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .imem_ena(imem_ena), .imem_wea(imem_wea),
        .imem_addra(imem_addra), .imem_dina(imem_dina), .core_rst(core_rst),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int wr_cnt = 0, exp_addr = 0;
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    logic [31:0] wv [0:63];

    typedef struct {
        logic [31:0] hdr;
        logic        e_done;
        logic        e_err;
    } hvec_t;
    hvec_t tbl [5];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // IMEM port A model plus per-write protocol checks
    always @(negedge clk) begin
        if (imem_ena === 1'b1) begin
            chk("wr_wea", 32'(imem_wea), 32'hF);
            chk("wr_rx_ready_low", 32'(rx_ready), 32'd0);
            chk("wr_addr", 32'(imem_addra), 32'(exp_addr));
            mem[imem_addra] = imem_dina;
            exp_addr++;
            wr_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        rx_valid = 1'b0;
        repeat (gap) tick();
        rx_data  = b;
        rx_valid = 1'b1;
        for (int k = 0; k < 40 && !got; k++) begin
            got = rx_ready;
            tick();
        end
        rx_valid = 1'b0;
        if (!got) begin
            n_chk++;
            n_fail++;
            $display("FAIL send_byte: no handshake within 40 cycles (byte %0h)", b);
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap_max);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t = w >> (8 * i);
            send_byte(t[7:0], $urandom_range(0, gap_max));
        end
    endtask

    task automatic wait_end();
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done || err) break;
        end
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 32'hDEAD_BEEF;
        wr_cnt = 0;
        exp_addr = 0;
    endtask

    // Full load of wv[0..n-1]; model: word i lands at address i, sum is plain 32-bit addition
    task automatic do_load(input int n, input int gap_max, input bit bad_sum, input bit poke);
        logic [31:0] sum = 32'd0;
        logic [31:0] nw  = 32'(n);
        clear_mem();
        pulse_start();
        @(negedge clk);
        chk("start_err_clear", 32'(err), 32'd0);
        chk("start_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] t = nw >> (8 * i);
            if (poke && i == 2) start = 1'b1;
            send_byte(t[7:0], $urandom_range(0, gap_max));
        end
        start = 1'b0;
        for (int i = 0; i < n; i++) begin
            send_word(wv[i], gap_max);
            sum += wv[i];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_word(bad_sum ? sum + 32'd1 : sum, gap_max);
`endif
        wait_end();
        if (bad_sum) begin
            chk("badsum_err", 32'(err), 32'd1);
            chk("badsum_core_rst", 32'(core_rst), 32'd1);
            chk("badsum_done", 32'(done), 32'd0);
        end else begin
            chk("load_done", 32'(done), 32'd1);
            chk("load_err", 32'(err), 32'd0);
            chk("load_core_rst", 32'(core_rst), 32'd0);
            chk("load_busy", 32'(busy), 32'd0);
        end
        chk("load_wr_cnt", 32'(wr_cnt), 32'(n));
        for (int i = 0; i < n; i++) chk("load_mem", mem[i], wv[i]);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'd0;
        #3;
        chk("rst_rx_ready", 32'(rx_ready), 32'd0);
        chk("rst_ena", 32'(imem_ena), 32'd0);
        chk("rst_wea", 32'(imem_wea), 32'd0);
        chk("rst_addra", 32'(imem_addra), 32'd0);
        chk("rst_dina", imem_dina, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Directed program image, back-to-back bytes
        wv[0] = 32'h0000_0013; wv[1] = 32'h0010_0093; wv[2] = 32'hFFDF_F06F;
        do_load(3, 0, 1'b0, 1'b0);

        // Header-only cases
        tbl[0] = '{hdr: 32'd0,          e_done: 1'b1, e_err: 1'b0};
        tbl[1] = '{hdr: 32'd16385,      e_done: 1'b0, e_err: 1'b1};
        tbl[2] = '{hdr: 32'h8000_0000,  e_done: 1'b0, e_err: 1'b1};
        tbl[3] = '{hdr: 32'hFFFF_FFFF,  e_done: 1'b0, e_err: 1'b1};
        tbl[4] = '{hdr: 32'd0,          e_done: 1'b1, e_err: 1'b0};
        for (int v = 0; v < 5; v++) begin
            clear_mem();
            pulse_start();
            @(negedge clk);
            chk("tbl_start_err_clear", 32'(err), 32'd0);
            send_word(tbl[v].hdr, 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
            if (tbl[v].hdr == 32'd0) send_word(32'd0, 1);
`endif
            @(negedge clk);
            chk("tbl_done", 32'(done), 32'(tbl[v].e_done));
            chk("tbl_err", 32'(err), 32'(tbl[v].e_err));
            chk("tbl_core_rst", 32'(core_rst), 32'(!tbl[v].e_done));
            chk("tbl_busy", 32'(busy), 32'd0);
            repeat (3) @(negedge clk);
            chk("tbl_no_writes", 32'(wr_cnt), 32'd0);
        end

        // Randomized images with 0..7 cycle gaps; odd runs hold start high mid-header
        for (int r = 0; r < 6; r++) begin
            int n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wv[i] = $urandom;
            do_load(n, 7, 1'b0, r[0]);
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        wv[0] = 32'd1; wv[1] = 32'd2;
        do_load(2, 2, 1'b0, 1'b0);
        do_load(2, 2, 1'b1, 1'b0);
`endif

        // Stream stalls after 2 bytes of word 1
        clear_mem();
        pulse_start();
        send_word(32'd2, 0);
        send_word(32'hCAFE_F00D, 0);
        send_byte(8'h11, 0);
        send_byte(8'h22, 0);
        repeat (14) tick();
        chk("tmo_not_yet", 32'(err), 32'd0);
        tick();
        chk("tmo_err", 32'(err), 32'd1);
        chk("tmo_core_rst", 32'(core_rst), 32'd1);
        chk("tmo_done", 32'(done), 32'd0);
        chk("tmo_rx_ready", 32'(rx_ready), 32'd0);
        chk("tmo_wr_cnt", 32'(wr_cnt), 32'd1);
        chk("tmo_word0", mem[0], 32'hCAFE_F00D);

        // Asynchronous reset in the middle of LOAD
        clear_mem();
        pulse_start();
        send_word(32'd4, 0);
        send_word(32'h1234_5678, 0);
        send_byte(8'h55, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_rx_ready", 32'(rx_ready), 32'd0);
        chk("arst_core_rst", 32'(core_rst), 32'd1);
        chk("arst_busy_done_err", {29'd0, busy, done, err}, 32'd0);
        chk("arst_ena_wea", {27'd0, imem_ena, imem_wea}, 32'd0);
        chk("arst_addr_dina", imem_dina | 32'(imem_addra), 32'd0);
        tick();
        rst = 1'b0;

        // Loader still usable after the reset
        wv[0] = 32'hA5A5_0001;
        do_load(1, 3, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1);
    end

endmodule
